// File: rtl/inflight_write_tracker_pkg.sv
// Shared types and constants for the in-flight write tracker.
package inflight_write_tracker_pkg;

    localparam int REG_NUM_W = 3;
    localparam int DATA_W    = 16;

    // One in-flight register write: destination, result and whether the result exists yet.
    typedef struct packed {
        logic                 write;
        logic                 ready;
        logic [REG_NUM_W-1:0] num;
        logic [DATA_W-1:0]    data;
    } inflight_slot_t;

    localparam inflight_slot_t SLOT_BUBBLE = '0;

    // Entry for a freshly issued instruction; its result is not known yet.
    function automatic inflight_slot_t make_issue_slot(input logic write,
                                                       input logic [REG_NUM_W-1:0] num);
        inflight_slot_t s;
        s       = SLOT_BUBBLE;
        s.write = write;
        s.num   = num;
        return s;
    endfunction

endpackage

// File: rtl/inflight_write_tracker_if.sv
// Issue/result/forwarding bundle between the pipeline and the in-flight write tracker.
interface inflight_write_tracker_if
    import inflight_write_tracker_pkg::*;
#(
    parameter int DEPTH = 6
);
    logic                       hold_in;
    logic                       flush_in;
    logic                       issue_valid_in;
    logic                       issue_write_in;
    logic [REG_NUM_W-1:0]       issue_num_in;
    logic [REG_NUM_W-1:0]       src_a_num_in;
    logic [REG_NUM_W-1:0]       src_b_num_in;
    logic                       src_a_used_in;
    logic                       src_b_used_in;
    logic                       alu_valid_in;
    logic [DATA_W-1:0]          alu_data_in;
    logic                       mem_valid_in;
    logic [DATA_W-1:0]          mem_data_in;
    logic [DEPTH-1:0]           m_write_out;
    logic [REG_NUM_W*DEPTH-1:0] m_num_out;
    logic [DATA_W*DEPTH-1:0]    m_data_out;
    logic                       stall_out;
    logic                       rf_we_out;
    logic [REG_NUM_W-1:0]       rf_num_out;
    logic [DATA_W-1:0]          rf_data_out;

    // Pipeline side: drives issue/results, observes forwarding views and stall.
    modport master (
        output hold_in, flush_in, issue_valid_in, issue_write_in, issue_num_in,
               src_a_num_in, src_b_num_in, src_a_used_in, src_b_used_in,
               alu_valid_in, alu_data_in, mem_valid_in, mem_data_in,
        input  m_write_out, m_num_out, m_data_out, stall_out,
               rf_we_out, rf_num_out, rf_data_out
    );

    // Tracker side.
    modport slave (
        input  hold_in, flush_in, issue_valid_in, issue_write_in, issue_num_in,
               src_a_num_in, src_b_num_in, src_a_used_in, src_b_used_in,
               alu_valid_in, alu_data_in, mem_valid_in, mem_data_in,
        output m_write_out, m_num_out, m_data_out, stall_out,
               rf_we_out, rf_num_out, rf_data_out
    );

endinterface

// File: rtl/inflight_write_tracker_track_youngest_match.sv
// Priority search for the youngest in-flight writer of one source register.
module track_youngest_match
    import inflight_write_tracker_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  inflight_slot_t       slots_i [DEPTH],
    input  logic [REG_NUM_W-1:0] num_i,
    output logic                 hit_o,
    output logic                 ready_o
);

    // Scan oldest to youngest so the youngest matching writer overrides older ones.
    always_comb begin
        hit_o   = 1'b0;
        ready_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slots_i[DEPTH-1-i].write && (slots_i[DEPTH-1-i].num == num_i)) begin
                hit_o   = 1'b1;
                ready_o = slots_i[DEPTH-1-i].ready;
            end
        end
    end

endmodule

// File: rtl/inflight_write_tracker.sv
// In-flight write tracker: shift register of pending register writes, forwarding
// views, load-use stall detection and oldest-slot retire to the register file.
module inflight_write_tracker
    import inflight_write_tracker_pkg::*;
#(
    parameter int DEPTH       = 6,
    parameter int ALU_STAGE   = 2,
    parameter int MEM_STAGE   = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    inflight_write_tracker_if.slave bus
);

    // Index 0 holds slot 1 (youngest), index DEPTH-1 holds slot DEPTH (oldest).
    inflight_slot_t       slots_q  [DEPTH];
    inflight_slot_t       slots_d  [DEPTH];
    inflight_slot_t       filled   [DEPTH];
    logic                 rf_we_q, rf_we_d;
    logic [REG_NUM_W-1:0] rf_num_q, rf_num_d;
    logic [DATA_W-1:0]    rf_data_q, rf_data_d;

    logic hit_a, ready_a, hit_b, ready_b;
    logic stall;

    track_youngest_match #(.DEPTH(DEPTH)) u_match_a (
        .slots_i (slots_q),
        .num_i   (bus.src_a_num_in),
        .hit_o   (hit_a),
        .ready_o (ready_a)
    );

    track_youngest_match #(.DEPTH(DEPTH)) u_match_b (
        .slots_i (slots_q),
        .num_i   (bus.src_b_num_in),
        .hit_o   (hit_b),
        .ready_o (ready_b)
    );

    // Stall only on registered readiness; a result arriving this cycle is seen next cycle.
    always_comb begin
        stall = (bus.src_a_used_in && hit_a && !ready_a) ||
                (bus.src_b_used_in && hit_b && !ready_b);
    end

    // Results land only in real, still-unready writes at their stage.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            filled[k] = slots_q[k];
        end
        if (bus.alu_valid_in && filled[ALU_STAGE-1].write && !filled[ALU_STAGE-1].ready) begin
            filled[ALU_STAGE-1].data  = bus.alu_data_in;
            filled[ALU_STAGE-1].ready = 1'b1;
        end
        if (bus.mem_valid_in && filled[MEM_STAGE-1].write && !filled[MEM_STAGE-1].ready) begin
            filled[MEM_STAGE-1].data  = bus.mem_data_in;
            filled[MEM_STAGE-1].ready = 1'b1;
        end
    end

    // Shift post-fill contents one age older, admit issue or bubble, then apply flush.
    always_comb begin
        if (bus.issue_valid_in && !stall && !bus.flush_in) begin
            slots_d[0] = make_issue_slot(bus.issue_write_in, bus.issue_num_in);
        end else begin
            slots_d[0] = SLOT_BUBBLE;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            slots_d[k] = filled[k-1];
        end
        if (bus.flush_in) begin
            for (int unsigned k = 0; k < FLUSH_DEPTH; k++) begin
                slots_d[k] = SLOT_BUBBLE;
            end
        end
    end

    // Oldest slot always leaves; only a ready write reaches the register file.
    always_comb begin
        rf_we_d   = filled[DEPTH-1].write && filled[DEPTH-1].ready;
        rf_num_d  = filled[DEPTH-1].num;
        rf_data_d = filled[DEPTH-1].data;
    end

    // State register: reset clears all, hold freezes slots and silences the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slots_q[k] <= SLOT_BUBBLE;
            end
            rf_we_q   <= 1'b0;
            rf_num_q  <= '0;
            rf_data_q <= '0;
        end else if (bus.hold_in) begin
            rf_we_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slots_q[k] <= slots_d[k];
            end
            rf_we_q   <= rf_we_d;
            rf_num_q  <= rf_num_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Flatten slot registers into the per-age forwarding views.
    always_comb begin
        bus.m_write_out = '0;
        bus.m_num_out   = '0;
        bus.m_data_out  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            bus.m_write_out[k]                  = slots_q[k].write;
            bus.m_num_out[k*REG_NUM_W +: REG_NUM_W] = slots_q[k].num;
            bus.m_data_out[k*DATA_W +: DATA_W]  = slots_q[k].data;
        end
    end

    // Drive stall and the registered write port.
    always_comb begin
        bus.stall_out   = stall;
        bus.rf_we_out   = rf_we_q;
        bus.rf_num_out  = rf_num_q;
        bus.rf_data_out = rf_data_q;
    end

endmodule

// File: tb/tb_inflight_write_tracker.sv
// Bench for inflight_write_tracker: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inflight_write_tracker;

    localparam int DEPTH = 6;
    localparam int ALU   = 2;
    localparam int MEM   = 4;
    localparam int FD    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inflight_write_tracker_if #(.DEPTH(DEPTH)) bus ();

    inflight_write_tracker #(
        .DEPTH(DEPTH), .ALU_STAGE(ALU), .MEM_STAGE(MEM), .FLUSH_DEPTH(FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of pending writes, [0] youngest ----------------
    typedef struct {
        bit        w;
        bit        r;
        bit [2:0]  n;
        bit [15:0] d;
    } ent_t;

    ent_t      pipe[$];
    bit        model_ok = 0;
    bit        m_rf_we;
    bit [2:0]  m_rf_num;
    bit [15:0] m_rf_data;

    function automatic bit unready_youngest(input bit used, input bit [2:0] src);
        if (!used) return 0;
        foreach (pipe[i]) begin
            if (pipe[i].w && pipe[i].n == src) return !pipe[i].r;
        end
        return 0;
    endfunction

    function automatic bit model_stall();
        return unready_youngest(bus.src_a_used_in, bus.src_a_num_in) ||
               unready_youngest(bus.src_b_used_in, bus.src_b_num_in);
    endfunction

    always @(posedge clk) begin
        ent_t e, z;
        bit   st;
        z = '{w: 0, r: 0, n: 0, d: 0};
        if (rst) begin
            pipe.delete();
            for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
            m_rf_we = 0; m_rf_num = 0; m_rf_data = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (bus.hold_in) begin
                m_rf_we = 0;
            end else begin
                st = model_stall();
                e = pipe[ALU-1];
                if (bus.alu_valid_in && e.w && !e.r) begin e.r = 1; e.d = bus.alu_data_in; pipe[ALU-1] = e; end
                e = pipe[MEM-1];
                if (bus.mem_valid_in && e.w && !e.r) begin e.r = 1; e.d = bus.mem_data_in; pipe[MEM-1] = e; end
                e = pipe.pop_back();
                m_rf_we = e.w && e.r; m_rf_num = e.n; m_rf_data = e.d;
                if (bus.issue_valid_in && !st && !bus.flush_in)
                    pipe.push_front('{w: bus.issue_write_in, r: 0, n: bus.issue_num_in, d: 0});
                else
                    pipe.push_front(z);
                if (bus.flush_in) for (int i = 0; i < FD; i++) pipe[i] = z;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [DEPTH-1:0]    ew;
        logic [3*DEPTH-1:0]  en;
        logic [16*DEPTH-1:0] ed;
        if (model_ok) begin
            ew = '0; en = '0; ed = '0;
            for (int k = 0; k < DEPTH; k++) begin
                ew[k] = pipe[k].w;
                en[3*k +: 3] = pipe[k].n;
                ed[16*k +: 16] = pipe[k].d;
            end
            chk("m_write", 128'(bus.m_write_out), 128'(ew));
            chk("m_num", 128'(bus.m_num_out), 128'(en));
            chk("m_data", 128'(bus.m_data_out), 128'(ed));
            chk("stall", 128'(bus.stall_out), 128'(model_stall()));
            chk("rf_we", 128'(bus.rf_we_out), 128'(m_rf_we));
            chk("rf_num", 128'(bus.rf_num_out), 128'(m_rf_num));
            chk("rf_data", 128'(bus.rf_data_out), 128'(m_rf_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hold_in = 0; bus.flush_in = 0;
        bus.issue_valid_in = 0; bus.issue_write_in = 0; bus.issue_num_in = 0;
        bus.src_a_num_in = 0; bus.src_b_num_in = 0;
        bus.src_a_used_in = 0; bus.src_b_used_in = 0;
        bus.alu_valid_in = 0; bus.alu_data_in = 0;
        bus.mem_valid_in = 0; bus.mem_data_in = 0;
    endtask

    task automatic issue(input bit [2:0] n);
        bus.issue_valid_in = 1; bus.issue_write_in = 1; bus.issue_num_in = n;
    endtask

    function automatic logic [2:0] slot_num(input int k);
        return bus.m_num_out[3*k-3 +: 3];
    endfunction

    function automatic logic [15:0] slot_data(input int k);
        return bus.m_data_out[16*k-16 +: 16];
    endfunction

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;

        // Reset then idle.
        repeat (8) tick();
        chk("rst_m_write", 128'(bus.m_write_out), 128'(0));
        chk("rst_m_num", 128'(bus.m_num_out), 128'(0));
        chk("rst_m_data", 128'(bus.m_data_out), 128'(0));
        chk("rst_stall", 128'(bus.stall_out), 128'(0));
        chk("rst_rf_we", 128'(bus.rf_we_out), 128'(0));

        // ALU result forwarded at slot 3, retired four cycles later.
        issue(3); tick(); idle_inputs();
        tick();
        bus.alu_valid_in = 1; bus.alu_data_in = 16'h1234; tick(); idle_inputs();
        chk("alu_s3_write", 128'(bus.m_write_out[2]), 128'(1));
        chk("alu_s3_num", 128'(slot_num(3)), 128'(3));
        chk("alu_s3_data", 128'(slot_data(3)), 128'(16'h1234));
        repeat (3) tick();
        chk("alu_pre_retire_we", 128'(bus.rf_we_out), 128'(0));
        tick();
        chk("alu_rf_we", 128'(bus.rf_we_out), 128'(1));
        chk("alu_rf_num", 128'(bus.rf_num_out), 128'(3));
        chk("alu_rf_data", 128'(bus.rf_data_out), 128'(16'h1234));

        // Load-use stall until the load result is captured at slot 4.
        issue(5); tick();
        issue(1); bus.src_a_num_in = 5; bus.src_a_used_in = 1; #1;
        chk("lu_stall_s1", 128'(bus.stall_out), 128'(1));
        tick();
        chk("lu_stall_s2", 128'(bus.stall_out), 128'(1));
        chk("lu_bubble_s1", 128'(bus.m_write_out[0]), 128'(0));
        tick(); tick();
        bus.mem_valid_in = 1; bus.mem_data_in = 16'hBEEF; #1;
        chk("lu_same_cycle_fill", 128'(bus.stall_out), 128'(1));
        tick(); bus.mem_valid_in = 0; #1;
        chk("lu_released", 128'(bus.stall_out), 128'(0));
        chk("lu_s5_data", 128'(slot_data(5)), 128'(16'hBEEF));
        tick(); idle_inputs();
        chk("lu_issued_s1", 128'(slot_num(1)), 128'(1));
        repeat (6) tick();

        // Ready older r2 shadowed by an unready younger r2: stall.
        issue(2); tick(); idle_inputs();
        tick();
        bus.alu_valid_in = 1; bus.alu_data_in = 16'hAAAA; tick(); idle_inputs();
        issue(2); tick(); idle_inputs();
        bus.src_a_num_in = 2; bus.src_a_used_in = 1; #1;
        chk("yng_unready_stall", 128'(bus.stall_out), 128'(1));
        idle_inputs();
        repeat (6) tick();

        // Unready older r2 shadowed by a ready younger r2: no stall (via src b).
        issue(2); tick();
        issue(2); tick(); idle_inputs();
        tick();
        bus.alu_valid_in = 1; bus.alu_data_in = 16'h0F0F; tick(); idle_inputs();
        bus.src_b_num_in = 2; bus.src_b_used_in = 1; #1;
        chk("yng_ready_nostall", 128'(bus.stall_out), 128'(0));
        idle_inputs();
        repeat (6) tick();

        // Flush squashes slots 1..2, the old slot-2 entry survives in slot 3.
        issue(1); tick();
        issue(2); tick();
        issue(3); tick();
        issue(4); bus.flush_in = 1; tick(); idle_inputs();
        chk("flush_s1", 128'(bus.m_write_out[0]), 128'(0));
        chk("flush_s2", 128'(bus.m_write_out[1]), 128'(0));
        chk("flush_s3_w", 128'(bus.m_write_out[2]), 128'(1));
        chk("flush_s3_num", 128'(slot_num(3)), 128'(2));
        repeat (6) tick();

        // Hold freezes state and ignores results; normal retire afterwards.
        issue(6); tick(); idle_inputs();
        tick();
        bus.hold_in = 1; bus.alu_valid_in = 1; bus.alu_data_in = 16'h5555;
        repeat (3) tick();
        chk("hold_s2_num", 128'(slot_num(2)), 128'(6));
        chk("hold_s2_data", 128'(slot_data(2)), 128'(0));
        chk("hold_s3_w", 128'(bus.m_write_out[2]), 128'(0));
        chk("hold_rf_we", 128'(bus.rf_we_out), 128'(0));
        bus.hold_in = 0; bus.alu_data_in = 16'h7777; tick(); idle_inputs();
        chk("post_hold_s3", 128'(slot_data(3)), 128'(16'h7777));
        repeat (4) tick();
        chk("post_hold_rf_we", 128'(bus.rf_we_out), 128'(1));
        chk("post_hold_rf_num", 128'(bus.rf_num_out), 128'(6));
        chk("post_hold_rf_data", 128'(bus.rf_data_out), 128'(16'h7777));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst                = ($urandom_range(0, 299) == 0);
            bus.hold_in        = ($urandom_range(0, 9) == 0);
            bus.flush_in       = ($urandom_range(0, 19) == 0);
            bus.issue_valid_in = ($urandom_range(0, 3) != 0);
            bus.issue_write_in = ($urandom_range(0, 4) != 0);
            bus.issue_num_in   = 3'($urandom);
            bus.src_a_num_in   = 3'($urandom);
            bus.src_b_num_in   = 3'($urandom);
            bus.src_a_used_in  = $urandom_range(0, 1);
            bus.src_b_used_in  = $urandom_range(0, 1);
            bus.alu_valid_in   = $urandom_range(0, 1);
            bus.alu_data_in    = 16'($urandom);
            bus.mem_valid_in   = $urandom_range(0, 1);
            bus.mem_data_in    = 16'($urandom);
            tick();
        end
        rst = 0;
        idle_inputs();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/inflight_write_tracker.md
Name: inflight_write_tracker

Overview:
- Producer side of operand forwarding: a DEPTH-slot shift register recording every in-flight register write (dest num, write enable, result data, ready flag).
- Exports per-age views m1..m6 (num/write/data) that feed the forwarding muxes.
- Retires the oldest slot to the register-file write port.
- Raises a load-use stall when the youngest in-flight producer of a source register has no result yet.

Parameters:
- DEPTH, 6: number of in-flight slots; slot 1 is youngest, slot DEPTH oldest.
- ALU_STAGE, 2: slot index that alu_valid_in/alu_data_in fill.
- MEM_STAGE, 4: slot index that mem_valid_in/mem_data_in fill; must be greater than ALU_STAGE and no greater than DEPTH.
- FLUSH_DEPTH, 2: slots 1..FLUSH_DEPTH are squashed by flush_in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- hold_in  in  1  global freeze: no shift, no fill, no retire.
- flush_in  in  1  squash the younger slots (branch mispredict).
- issue_valid_in  in  1  instruction entering slot 1 this cycle.
- issue_write_in  in  1  issued instruction writes a register.
- issue_num_in  in  3  destination register of the issued instruction.
- src_a_num_in, src_b_num_in  in  3 each  source registers of the instruction being issued.
- src_a_used_in, src_b_used_in  in  1 each  source is actually read.
- alu_valid_in  in  1  ALU result available for slot ALU_STAGE.
- alu_data_in  in  16  ALU result.
- mem_valid_in  in  1  load result available for slot MEM_STAGE.
- mem_data_in  in  16  load result.
- m_write_out  out  DEPTH  bit k-1 = slot k write flag.
- m_num_out  out  3*DEPTH  bits [3k-1:3k-3] = slot k dest num.
- m_data_out  out  16*DEPTH  bits [16k-1:16k-16] = slot k data.
- stall_out  out  1  issue must be held; a bubble is inserted.
- rf_we_out, rf_num_out(3), rf_data_out(16)  out  register-file write port (registered).

Behaviour:
- Reset: all slots cleared (write=0, num=0, data=0, ready=0); every output 0. A reset mid-operation discards all in-flight entries with no retire.
- Slot outputs are combinational views of the slot registers. No added latency.
- hazard_x for source x (a or b) = src_x_used_in and the youngest slot k with write=1 and num==src_x_num_in has ready=0.
- Only the youngest match counts. An older unready match hidden behind a ready younger match does not stall.
- stall_out = hazard_a | hazard_b, using registered ready only. A same-cycle alu_valid_in/mem_valid_in does not clear the stall.
- Each clock, in priority order:
  - rst: clear everything.
  - hold_in: all state frozen; rf_we_out <= 0.
  - Otherwise:
    - Fill: if alu_valid_in and slot ALU_STAGE write=1 and ready=0, slot ALU_STAGE takes alu_data_in and ready=1. The same rule applies to mem_valid_in at slot MEM_STAGE. A fill into a bubble or an already-ready slot is ignored.
    - Retire: rf_we_out <= slot DEPTH write & ready; rf_num_out/rf_data_out <= slot DEPTH num/data. An unready write at retire is dropped and rf_we_out = 0.
    - Shift: slot k+1 <= slot k, post-fill contents.
    - Slot 1 <= issue entry if issue_valid_in & !stall_out & !flush_in; otherwise a bubble (all zero).
    - Flush: after the shift, slots 1..FLUSH_DEPTH are forced to bubbles (write=0, ready=0). Flush overrides issue and stall.
- Issue with issue_write_in=0 enters as write=0, ready=0.
- There is no wrap-around. The oldest slot always leaves, even while stalled: a stall only inserts bubbles.

Decomposition:
- Shared package: typedef inflight_slot_t {write, ready, num[2:0], data[15:0]}; constants REG_NUM_W=3, DATA_W=16.
- Sub-module track_youngest_match: combinational priority search over slots for one source, returning hit and ready. Instantiated twice, for src a and src b.

Test Plan:
- Reset then idle 8 cycles -> all outputs 0, stall_out=0, rf_we_out=0.
- Issue write r3 at cycle 0; alu_valid_in=1, data 0x1234 at cycle 2 -> m_num slot3=3 with data 0x1234 at cycle 3; rf_we_out=1, num 3, data 0x1234 at cycle 7.
- Load r5 issued, next instruction reads r5 -> stall_out=1 until mem_valid_in fills slot 4, then 0 the following cycle; bubbles appear at slot 1 during the stall.
- Write r2 (ready, 0xAAAA) older, then unready write r2 younger; src r2 -> stall_out=1. Reverse the order -> stall_out=0.
- flush_in with writes in slots 1..3 -> next cycle slots 1..2 write=0, old slot 2 entry survives in slot 3.
- hold_in for 3 cycles mid-stream -> slot contents unchanged, rf_we_out=0, alu_valid_in ignored; normal retire afterward.
